instr_encode_loader: RTL

//  Inverse of the instruction decoder. Accepts MIPS instruction fields over a valid/ready stream.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/instr_packer.sv | 52 +++++
 rtl/instr_encode_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and the program-loader state type.
// Used by instr_packer and instr_encode_loader.
package mips_pkg;

    // Instruction format codes, identical to the decoder's Type field
    localparam logic [1:0] FMT_I   = 2'b00;
    localparam logic [1:0] FMT_J   = 2'b01;
    localparam logic [1:0] FMT_R   = 2'b10;
    localparam logic [1:0] FMT_NOP = 2'b11;

    // Opcodes that select the R and J formats
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;

    // Function codes of the only R instructions that use the shamt field
    localparam logic [5:0] FUN_SLL = 6'h00;
    localparam logic [5:0] FUN_SRL = 6'h02;
    localparam logic [5:0] FUN_SRA = 6'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

    // True for the two jump opcodes (6'b00001?)
    function automatic logic is_jump_opc(input logic [5:0] opc);
        return (opc == OPC_J) || (opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: instruction fields -> 32-bit MIPS word.
// The illegal flag is only live when the ENC_CHECK_EN macro is defined;
// otherwise it is constant 0 and every beat is encoded as-is.
module instr_packer (
    input  logic [1:0]  fmt,
    input  logic [5:0]  opc,
    input  logic [5:0]  fun,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm,
    input  logic [25:0] iindex,
    output logic [31:0] word,
    output logic        illegal
);
    import mips_pkg::*;

`ifdef ENC_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic bad;

    // Assemble the word for the selected format; fields a format does not use are ignored
    always_comb begin
        word = 32'h0;
        case (fmt)
            FMT_R:   word = {opc, rs, rt, rd, sa, fun};
            FMT_I:   word = {opc, rs, rt, imm};
            FMT_J:   word = {opc, iindex};
            default: word = 32'h0;
        endcase
    end

    // Detect field combinations the decoder would not map back to the same format
    always_comb begin
        bad = 1'b0;
        case (fmt)
            FMT_R:   bad = (opc != OPC_SPECIAL) ||
                           ((sa != 5'd0) && !((fun == FUN_SLL) || (fun == FUN_SRL) || (fun == FUN_SRA)));
            FMT_J:   bad = !is_jump_opc(opc);
            FMT_I:   bad = (opc == OPC_SPECIAL) || is_jump_opc(opc);
            default: bad = 1'b0;
        endcase
    end

    assign illegal = CHECK_EN & bad;

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: takes instruction fields over a valid/ready stream, packs
// them into MIPS words and writes them to consecutive IMEM addresses starting
// at BASE_ADDR. Optional field legality checking via the ENC_CHECK_EN macro.
module instr_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_opc,
    input  logic [5:0]        in_fun,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_sa,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_iindex,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic              enc_err
);
    import mips_pkg::*;

    localparam int              CAP_INT  = (1 << ADDR_W) - BASE_ADDR;
    localparam logic [ADDR_W:0]   CAPACITY = CAP_INT[ADDR_W:0];
    localparam logic [ADDR_W-1:0] BASE_PTR = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    loader_state_e     state;
    loader_state_e     state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              full;
    logic              accept;
    logic              write_ok;
    logic              offered_full;
    logic [31:0]       packed_word;
    logic              packed_illegal;

    instr_packer u_packer (
        .fmt     (in_fmt),
        .opc     (in_opc),
        .fun     (in_fun),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .sa      (in_sa),
        .imm     (in_imm),
        .iindex  (in_iindex),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    // start always wins over a beat in the same cycle, so it masks acceptance
    assign full         = (word_count >= CAPACITY);
    assign in_ready     = (state == ST_LOAD) && !full;
    assign accept       = in_valid && in_ready && !start;
    assign write_ok     = accept && !packed_illegal;
    assign offered_full = (state == ST_LOAD) && full && in_valid && !start;
    assign busy         = (state == ST_LOAD);
    assign done         = (state == ST_DONE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start restarts from anywhere; LOAD ends on the last beat or on a beat offered while full
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_LOAD;
        end else if (state == ST_LOAD) begin
            if (accept && in_last) begin
                state_nxt = ST_DONE;
            end else if (offered_full) begin
                state_nxt = ST_DONE;
            end
        end
    end

    // Write port, pointer, word count and overflow; the pointer saturates instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            ptr        <= BASE_PTR;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= write_ok;
            if (start) begin
                ptr        <= BASE_PTR;
                word_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (write_ok) begin
                    imem_addr  <= ptr;
                    imem_wdata <= packed_word;
                    word_count <= word_count + 1'b1;
                    if (ptr != LAST_PTR) begin
                        ptr <= ptr + 1'b1;
                    end
                end
                if (offered_full) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef ENC_CHECK_EN
    // Sticky flag for beats that were accepted but dropped as illegal
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_err <= 1'b0;
        end else if (start) begin
            enc_err <= 1'b0;
        end else if (accept && packed_illegal) begin
            enc_err <= 1'b1;
        end
    end
`else
    assign enc_err = 1'b0;
`endif

endmodule
